// File: rtl/uart_rx_core_pkg.sv
// Shared UART definitions: receiver state encoding, frame geometry and the
// baud divisor helper used by both halves of the UART.
package uart_rx_core_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_OVERSAMPLE  = 16;
    localparam int UART_SYNC_STAGES = 2;
    localparam int UART_DVSR_W      = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // A divisor of zero would never tick, so it is run as a divisor of one.
    function automatic logic [UART_DVSR_W-1:0] eff_dvsr(input logic [UART_DVSR_W-1:0] dvsr);
        return (dvsr == '0) ? UART_DVSR_W'(1) : dvsr;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Receiver bus: baud setting and serial line in, recovered byte and status out.
// RX_DONE is a valid-only strobe (no ready): DOUT_RX is valid in that cycle and held until the next frame.
interface uart_rx_core_if
    import uart_rx_core_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    logic [UART_DVSR_W-1:0] DVSR;
    logic                   RX;
    logic [DATA_BITS-1:0]   DOUT_RX;
    logic                   RX_DONE;
    logic                   FRAME_ERR;
    logic                   RX_BUSY;
    rx_state_t              state;

    modport master (
        output DVSR,
        output RX,
        input  DOUT_RX,
        input  RX_DONE,
        input  FRAME_ERR,
        input  RX_BUSY,
        input  state
    );

    modport slave (
        input  DVSR,
        input  RX,
        output DOUT_RX,
        output RX_DONE,
        output FRAME_ERR,
        output RX_BUSY,
        output state
    );

endinterface

// File: rtl/uart_rx_core_baud_gen.sv
// Baud tick generator: one-clock TICK every DVSR clocks; a new DVSR is picked
// up only when the counter wraps so a running period is never cut short.
module uart_baud_gen
    import uart_rx_core_pkg::*;
(
    input  logic                   i_CLK,
    input  logic                   i_RST_n,
    input  logic [UART_DVSR_W-1:0] DVSR,
    output logic                   TICK
);

    logic [UART_DVSR_W-1:0] cnt_q;
    logic [UART_DVSR_W-1:0] last_q;

    assign TICK = (cnt_q == last_q);

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else if (TICK) begin
            cnt_q  <= '0;
            last_q <= eff_dvsr(DVSR) - UART_DVSR_W'(1);
        end else begin
            cnt_q  <= cnt_q + UART_DVSR_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 16x oversampling: synchronises RX, finds the start
// bit, samples every bit at its centre and reports the byte and stop-bit status.
module uart_rx_core
    import uart_rx_core_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int SYNC_STAGES = UART_SYNC_STAGES
) (
    input  logic           i_CLK,
    input  logic           i_RST_n,
    uart_rx_core_if.slave  bus
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    logic                   tick;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    rx_state_t              state_q;
    logic [SW-1:0]          s_cnt_q;
    logic [NW-1:0]          n_cnt_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic [DATA_BITS-1:0]   dout_q;
    logic                   done_q;
    logic                   ferr_q;
    logic                   busy_q;

    uart_baud_gen u_baud_gen (
        .i_CLK   (i_CLK),
        .i_RST_n (i_RST_n),
        .DVSR    (bus.DVSR),
        .TICK    (tick)
    );

    // Preset to idle-high so reset never looks like a start bit.
    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.RX};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q <= START;
                        s_cnt_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s_cnt_q == S_MID) begin
                            // Still low at mid start bit: a real frame, not a glitch.
                            if (!rx_s) begin
                                state_q <= DATA;
                                s_cnt_q <= '0;
                                n_cnt_q <= '0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + SW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s_cnt_q == S_LAST) begin
                            shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
                            s_cnt_q <= '0;
                            if (n_cnt_q == N_LAST) begin
                                state_q <= STOP;
                            end else begin
                                n_cnt_q <= n_cnt_q + NW'(1);
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + SW'(1);
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (s_cnt_q == S_LAST) begin
                            dout_q  <= shreg_q;
                            done_q  <= 1'b1;
                            s_cnt_q <= '0;
                            if (rx_s) begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= BREAK;
                            end
                        end else begin
                            s_cnt_q <= s_cnt_q + SW'(1);
                        end
                    end
                end
                BREAK: begin
                    // Hold off until the line is released so a long low is one event.
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DOUT_RX   = dout_q;
    assign bus.RX_DONE   = done_q;
    assign bus.FRAME_ERR = ferr_q;
    assign bus.RX_BUSY   = busy_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames are driven bit by bit and every
// RX_DONE is checked against a queue of bytes the line actually carried.
module tb_uart_rx_core;
  import uart_rx_core_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_core_if u_if ();

  uart_rx_core dut (
    .i_CLK   (clk),
    .i_RST_n (rst_n),
    .bus     (u_if.slave)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];      // {frame_err, byte}
  int start_q[$];            // clock on which the start edge is first captured
  int d_q[$];                // effective clocks per tick for that frame
  int done_cyc_q[$];
  logic [7:0] model_dout = 8'h00;
  logic prev_done = 1'b0;
  int last_lat = 0;
  int lat = 0;
  int e_start = 0;
  int e_d = 0;
  logic [8:0] e_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      model_dout = 8'h00;
      prev_done = 1'b0;
      check("rst_dout", u_if.DOUT_RX, 32'h0);
      check("rst_done", u_if.RX_DONE, 32'h0);
      check("rst_ferr", u_if.FRAME_ERR, 32'h0);
      check("rst_busy", u_if.RX_BUSY, 32'h0);
    end else begin
      if (u_if.RX_DONE) begin
        check("done_width", prev_done, 32'h0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got RX_DONE data %0h expected no frame at cycle %0d", u_if.DOUT_RX, cyc);
        end else begin
          e_val = exp_q.pop_front();
          e_start = start_q.pop_front();
          e_d = d_q.pop_front();
          model_dout = e_val[7:0];
          check("frame_err", u_if.FRAME_ERR, 32'(e_val[8]));
          check("busy_at_done", u_if.RX_BUSY, 32'(e_val[8]));
          // Start detect after 2 sync clocks, then 152 ticks to mid stop bit.
          lat = cyc - e_start;
          last_lat = lat;
          done_cyc_q.push_back(cyc);
          checks++;
          if (lat < 151 * e_d + 3 || lat > 152 * e_d + 2) begin
            errors++;
            $display("FAIL done_latency: got %0d expected %0d..%0d", lat, 151 * e_d + 3, 152 * e_d + 2);
          end
        end
      end else if (u_if.FRAME_ERR) begin
        checks++;
        errors++;
        $display("FAIL ferr_alone: got FRAME_ERR=1 expected 0 without RX_DONE at cycle %0d", cyc);
      end
      check("dout_hold", u_if.DOUT_RX, 32'(model_dout));
      prev_done = u_if.RX_DONE;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic send_frame(input logic [7:0] data, input logic stop, input int stop_bits, input int d);
    int bit_clk;
    bit_clk = 16 * eff(d);
    u_if.RX = 1'b0;
    start_q.push_back(cyc + 1);
    d_q.push_back(eff(d));
    exp_q.push_back({~stop, data});
    hold(bit_clk);
    for (int i = 0; i < 8; i++) begin
      u_if.RX = data[i];
      hold(bit_clk);
    end
    u_if.RX = stop;
    hold(bit_clk * stop_bits);
  endtask

  // ---------------- stimulus ----------------
  int lat0;
  logic [7:0] abort_byte;
  logic [7:0] b2b [4];

  initial begin
    u_if.RX = 1'b1;
    u_if.DVSR = 6'd53;
    b2b[0] = 8'hAB; b2b[1] = 8'hF7; b2b[2] = 8'h96; b2b[3] = 8'h3D;
    abort_byte = 8'hF2;

    hold(3);
    check("reset_state", u_if.state, 32'(IDLE));
    rst_n = 1'b1;
    hold(5);
    check("post_reset_state", u_if.state, 32'(IDLE));
    check("post_reset_busy", u_if.RX_BUSY, 32'h0);

    // 1: single frame 0x3D
    send_frame(8'h3D, 1'b1, 1, 53);
    hold(20);
    check("t1_dout", u_if.DOUT_RX, 32'h3D);
    check("t1_state", u_if.state, 32'(IDLE));

    // 2: short low glitch rejected
    u_if.RX = 1'b0;
    hold(100);
    check("t2_busy_during", u_if.RX_BUSY, 32'h1);
    hold(59);
    u_if.RX = 1'b1;
    hold(600);
    check("t2_busy_after", u_if.RX_BUSY, 32'h0);
    check("t2_state", u_if.state, 32'(IDLE));
    check("t2_dout", u_if.DOUT_RX, 32'h3D);

    // 3: 0xA5 with low stop bit held two bit times, then a clean frame
    send_frame(8'hA5, 1'b0, 2, 53);
    check("t3_dout", u_if.DOUT_RX, 32'hA5);
    check("t3_break_state", u_if.state, 32'(BREAK));
    check("t3_break_busy", u_if.RX_BUSY, 32'h1);
    u_if.RX = 1'b1;
    hold(10);
    check("t3_idle_state", u_if.state, 32'(IDLE));
    check("t3_idle_busy", u_if.RX_BUSY, 32'h0);
    hold(200);
    send_frame(8'h3C, 1'b1, 1, 53);
    hold(20);
    check("t3_next_dout", u_if.DOUT_RX, 32'h3C);

    // 4: four back-to-back frames
    done_cyc_q.delete();
    for (int i = 0; i < 4; i++) send_frame(b2b[i], 1'b1, 1, 53);
    hold(20);
    check("t4_count", done_cyc_q.size(), 32'd4);
    if (done_cyc_q.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check("t4_spacing", done_cyc_q[i] - done_cyc_q[i-1], 32'd8480);
    end
    check("t4_last_dout", u_if.DOUT_RX, 32'h3D);

    // 5: reset pulse during bit 4 of 0xF2; bits 4..7 are 1 so the line stays idle after
    u_if.RX = 1'b0;
    hold(848);
    for (int i = 0; i < 4; i++) begin
      u_if.RX = abort_byte[i];
      hold(848);
    end
    u_if.RX = abort_byte[4];
    check("t5_busy_before", u_if.RX_BUSY, 32'h1);
    hold(424);
    #1 rst_n = 1'b0;
    #2;
    check("t5_rst_dout", u_if.DOUT_RX, 32'h0);
    check("t5_rst_busy", u_if.RX_BUSY, 32'h0);
    check("t5_rst_state", u_if.state, 32'(IDLE));
    #5 rst_n = 1'b1;
    u_if.RX = 1'b1;
    hold(100);
    send_frame(8'h55, 1'b1, 1, 53);
    hold(20);
    check("t5_dout", u_if.DOUT_RX, 32'h55);

    // 6: DVSR=0 and DVSR=1 both give 16 clk/bit
    u_if.DVSR = 6'd0;
    hold(200);
    send_frame(8'hC3, 1'b1, 1, 0);
    hold(20);
    check("t6_dout_d0", u_if.DOUT_RX, 32'hC3);
    lat0 = last_lat;
    u_if.DVSR = 6'd1;
    hold(200);
    send_frame(8'hC3, 1'b1, 1, 1);
    hold(20);
    check("t6_dout_d1", u_if.DOUT_RX, 32'hC3);
    check("t6_same_timing", last_lat, 32'(lat0));

    check("pending_frames", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
